// File: rtl/irq_sink.sv
// irq_sink: edge/level irq capture into pending/overrun, enable mask, W1C + claim-by-read regs, registered irq_o
module irq_sink #(
  parameter int N_IRQ     = 8,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             reg_wr_en,
  input  logic             reg_rd_en,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_rvalid,
  output logic             irq_o
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  logic [N_IRQ-1:0] pending, enable, overrun, irq_prev, cap, act, sel, clr, wd;
  logic [ID_W-1:0]  id;
  logic [31:0]      rd_mux;
  logic             claim;
  assign wd    = reg_wdata[N_IRQ-1:0];
  assign cap   = EDGE_MODE ? irq_i & ~irq_prev : irq_i;
  assign act   = pending & enable;
  assign claim = reg_rd_en && reg_addr == 2'd2;
  assign sel   = claim ? (N_IRQ'(1) << id) & act : '0;
  assign clr   = ((reg_wr_en && reg_addr == 2'd0) ? wd : '0) | sel;
  always_comb begin
    id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (act[i]) id = ID_W'(i);
  end
  always_comb
    rd_mux = reg_addr == 2'd0 ? 32'(pending) :
             reg_addr == 2'd1 ? 32'(enable)  :
             reg_addr == 2'd3 ? 32'(overrun) :
             |act             ? (32'h8000_0000 | 32'(id)) : 32'h0;
  always_ff @(posedge aclk)
    if (rst) begin
      pending    <= '0;
      enable     <= '0;
      overrun    <= '0;
      irq_prev   <= '0;
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      irq_prev   <= irq_i;
      pending    <= cap | (pending & ~clr);
      overrun    <= (cap & pending) | (overrun & ~((reg_wr_en && reg_addr == 2'd3) ? wd : '0));
      irq_o      <= |act;
      reg_rvalid <= reg_rd_en;
      if (reg_wr_en && reg_addr == 2'd1) enable <= wd;
      if (reg_rd_en) reg_rdata <= rd_mux;
    end
  generate
    if (N_IRQ < 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^reg_wdata[31:N_IRQ];
    end
  endgenerate
endmodule

// File: tb/tb_irq_sink.sv
// tb_irq_sink: table-driven and directed checks of irq_sink in edge and level capture modes
module tb_irq_sink;
  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq_i = '0;
  logic        reg_wr_en = 1'b0;
  logic        reg_rd_en = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] rdata_e, rdata_l;
  logic        rv_e, rv_l, irqo_e, irqo_l;
  int          checks = 0;
  int          passed = 0;
  typedef struct {
    logic        r;
    logic [7:0]  irq;
    logic        wr;
    logic        rd;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        rv;
    logic        cd;
    logic [31:0] rdat;
    logic        io;
  } vec_t;
  vec_t tv[$];
  always #5 aclk = ~aclk;
  irq_sink #(.N_IRQ(8), .EDGE_MODE(1'b1)) dut_e (
    .aclk(aclk), .rst(rst), .irq_i(irq_i), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_e), .reg_rvalid(rv_e), .irq_o(irqo_e)
  );
  irq_sink #(.N_IRQ(8), .EDGE_MODE(1'b0)) dut_l (
    .aclk(aclk), .rst(rst), .irq_i(irq_i), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(rdata_l), .reg_rvalid(rv_l), .irq_o(irqo_l)
  );
  function automatic vec_t mk(input logic r, input logic [7:0] irq, input logic wr, input logic rd,
                              input logic [1:0] a, input logic [31:0] wd, input logic rv, input logic cd,
                              input logic [31:0] rdat, input logic io);
    vec_t v;
    v.r = r; v.irq = irq; v.wr = wr; v.rd = rd; v.a = a; v.wd = wd;
    v.rv = rv; v.cd = cd; v.rdat = rdat; v.io = io;
    return v;
  endfunction
  task automatic drive(input logic r, input logic [7:0] irq_v, input logic wr, input logic rd,
                       input logic [1:0] a, input logic [31:0] wd);
    rst = r; irq_i = irq_v; reg_wr_en = wr; reg_rd_en = rd; reg_addr = a; reg_wdata = wd;
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic hi_seen;
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 32'h0,        0, 1, 32'h0,        0));
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 32'h0,        0, 1, 32'h0,        0));
    tv.push_back(mk(1, 8'h00, 0, 0, 0, 32'h0,        0, 1, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 32'h5,        0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h04, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1));
    tv.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        1, 1, 32'h4,        1));
    tv.push_back(mk(0, 8'h00, 0, 1, 1, 32'h0,        1, 1, 32'h5,        1));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 32'h4,        0, 0, 32'h0,        1));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 32'hFF,       0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h0A, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1));
    tv.push_back(mk(0, 8'h00, 0, 1, 2, 32'h0,        1, 1, 32'h80000001, 1));
    tv.push_back(mk(0, 8'h00, 0, 1, 2, 32'h0,        1, 1, 32'h80000003, 1));
    tv.push_back(mk(0, 8'h00, 0, 1, 2, 32'h0,        1, 1, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        1, 1, 32'h0,        0));
    tv.push_back(mk(0, 8'h08, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1));
    tv.push_back(mk(0, 8'h08, 1, 0, 0, 32'h8,        0, 0, 32'h0,        1));
    tv.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        1, 1, 32'h8,        1));
    tv.push_back(mk(0, 8'h00, 0, 1, 3, 32'h0,        1, 1, 32'h8,        1));
    tv.push_back(mk(0, 8'h00, 1, 0, 3, 32'h8,        0, 0, 32'h0,        1));
    tv.push_back(mk(0, 8'h00, 0, 1, 3, 32'h0,        1, 1, 32'h0,        1));
    tv.push_back(mk(0, 8'h00, 1, 1, 0, 32'h8,        1, 1, 32'h8,        1));
    tv.push_back(mk(0, 8'h00, 0, 1, 0, 32'h0,        1, 1, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 1, 0, 2, 32'hFFFFFFFF, 0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 0, 1, 1, 32'h0,        1, 1, 32'hFF,       0));
    tv.push_back(mk(0, 8'h00, 1, 0, 1, 32'hFFFFFF01, 0, 0, 32'h0,        0));
    tv.push_back(mk(0, 8'h00, 0, 1, 1, 32'h0,        1, 1, 32'h1,        0));
    tv.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,        0, 1, 32'h1,        0));
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].r, tv[i].irq, tv[i].wr, tv[i].rd, tv[i].a, tv[i].wd);
      chk($sformatf("v%0d rvalid", i), 32'(rv_e), 32'(tv[i].rv));
      chk($sformatf("v%0d irq_o", i), 32'(irqo_e), 32'(tv[i].io));
      if (tv[i].cd) chk($sformatf("v%0d rdata", i), rdata_e, tv[i].rdat);
    end
    drive(0, 8'h00, 1, 0, 1, 32'h0);
    hi_seen = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      drive(0, 8'h02, 0, 0, 0, 32'h0);
      hi_seen |= irqo_e;
    end
    chk("mask irq_o held low", 32'(hi_seen), 32'h0);
    drive(0, 8'h00, 0, 1, 0, 32'h0);
    chk("mask pending", rdata_e, 32'h2);
    drive(0, 8'h00, 0, 1, 3, 32'h0);
    chk("mask no overrun", rdata_e, 32'h0);
    drive(0, 8'h00, 1, 0, 1, 32'h2);
    chk("unmask same edge", 32'(irqo_e), 32'h0);
    drive(0, 8'h00, 0, 0, 0, 32'h0);
    chk("unmask next edge", 32'(irqo_e), 32'h1);
    drive(1, 8'h00, 0, 0, 0, 32'h0);
    drive(0, 8'h01, 0, 0, 0, 32'h0);
    drive(0, 8'h01, 1, 0, 0, 32'h1);
    drive(0, 8'h01, 0, 1, 0, 32'h0);
    chk("level pending held", rdata_l, 32'h1);
    drive(0, 8'h00, 1, 0, 0, 32'h1);
    drive(0, 8'h00, 0, 1, 0, 32'h0);
    chk("level pending cleared", rdata_l, 32'h0);
    chk("level rvalid", 32'(rv_l), 32'h1);
    drive(0, 8'h00, 1, 0, 1, 32'hFF);
    drive(0, 8'h14, 0, 0, 0, 32'h0);
    drive(0, 8'h00, 0, 1, 2, 32'h0);
    chk("pre-reset claim", rdata_e, 32'h80000002);
    drive(1, 8'h00, 0, 0, 0, 32'h0);
    chk("reset rvalid", 32'(rv_e), 32'h0);
    chk("reset rdata", rdata_e, 32'h0);
    chk("reset irq_o", 32'(irqo_e), 32'h0);
    drive(0, 8'h00, 0, 1, 0, 32'h0);
    chk("post-reset pending", rdata_e, 32'h0);
    chk("post-reset irq_o", 32'(irqo_e), 32'h0);
    drive(0, 8'h00, 0, 1, 1, 32'h0);
    chk("post-reset enable", rdata_e, 32'h0);
    drive(0, 8'h00, 0, 1, 3, 32'h0);
    chk("post-reset overrun", rdata_e, 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/irq_sink.md
Name: irq_sink

Overview:
- Interrupt receiver/controller for the register-station subsystem. Collects up to N_IRQ single-bit interrupt lines from error-IRQ generators in the same clock domain.
- Detects each assertion, latches it as pending, applies a software enable mask and drives one aggregated irq_o to the host.
- A small register port provides status read, W1C clear, enable programming and claim-by-read with lowest-index priority.

Parameters:
- N_IRQ, 8, number of interrupt sources (1..32).
- EDGE_MODE, 1'b1, 1 = capture on rising edge of irq_i[n]; 0 = level capture (pending re-set every cycle the line is high).

Ports:
- aclk  in  1  clock.
- rst  in  1  reset.
- irq_i  in  N_IRQ  interrupt source lines, synchronous to aclk.
- reg_wr_en  in  1  write strobe, single-cycle.
- reg_rd_en  in  1  read strobe, single-cycle.
- reg_addr  in  2  word address: 0 PENDING, 1 ENABLE, 2 CLAIM, 3 OVERRUN.
- reg_wdata  in  32  write data; bits above N_IRQ-1 are ignored.
- reg_rdata  out  32  read data, valid while reg_rvalid=1.
- reg_rvalid  out  1  read-data valid, one-cycle pulse.
- irq_o  out  1  aggregated interrupt, registered.

Interface: one clock, aclk; reset is synchronous and active-high (rst).

Behaviour:
- Reset (rst=1 at a rising aclk edge) clears pending, enable, overrun, irq_prev, reg_rdata, reg_rvalid and irq_o. Reset has priority over all other activity, including a read or claim in flight. ID_W = max(1, $clog2(N_IRQ)).
- Capture event cap[n]:
  - EDGE_MODE=1: cap[n] = irq_i[n] & ~irq_prev[n]. irq_prev is a register of irq_i.
  - EDGE_MODE=0: cap[n] = irq_i[n].
  - A held-high line produces exactly one event in edge mode.
- Pending update per bit, evaluated at each edge:
  - set if cap[n];
  - otherwise cleared if a W1C to PENDING has wdata[n]=1, or a CLAIM read selects n;
  - otherwise hold.
  - Set wins over a same-cycle clear.
- Overrun: overrun[n] is set when cap[n]=1 while pending[n] is already 1 (before this edge's update). It is cleared by a W1C to OVERRUN; a same-cycle set wins.
- ENABLE: read/write register, N_IRQ bits. Masking does not stop pending capture.
- irq_o: registered OR of (pending & enable), using register values from the previous cycle. Latency is 2 cycles from irq_i rising at edge k: pending is set at k, irq_o=1 at k+1.
  - A clear or disable at edge k drops irq_o at k+1.
- Reads:
  - reg_rd_en at edge k gives reg_rvalid=1 and reg_rdata at k+1.
  - Read values are pre-update values from edge k.
  - Unused upper bits read 0. reg_rdata holds its last value when rvalid=0.
- CLAIM read:
  - Selects the lowest index n with pending[n]&enable[n].
  - Returns bit31=1, bits[ID_W-1:0]=n, and clears pending[n] (subject to set-wins).
  - If none is selected, returns 0 and has no side effect.
- Writes to CLAIM are ignored.
- Read and write in the same cycle are both performed. The read returns pre-write values. If a W1C and a claim hit the same bit, the bit is cleared once; no error.
- Protocol misuse is not checked: reg_rd_en/reg_wr_en held high simply act every cycle.

Test Plan:
- Reset and capture: rst for 3 cycles, all outputs 0; ENABLE=0x05, pulse irq_i[2] for 1 cycle → PENDING reads 0x04 and irq_o=1 two cycles after the rise.
- Masking: ENABLE=0x00, irq_i[1] held high for 1024 cycles → PENDING=0x02 (single event, no overrun), irq_o=0; then write ENABLE=0x02 → irq_o=1 one cycle later.
- Claim priority: pending=0x0A, enable=0xFF → CLAIM reads 0x80000001 then 0x80000003 then 0x00000000; irq_o drops one cycle after the second claim.
- Set-wins and overrun: pending[3]=1, W1C PENDING 0x08 in the same cycle as a new irq_i[3] rising edge → pending[3] stays 1, OVERRUN reads 0x08; write OVERRUN 0x08 → reads 0x00.
- Level mode (EDGE_MODE=0): irq_i[0] high, W1C 0x01 → PENDING still 0x01; drop irq_i[0], W1C 0x01 → 0x00.
- Reset mid-read: rst asserted in the cycle after reg_rd_en → reg_rvalid=0 and reg_rdata=0 after that edge; all state cleared.
